// File: rtl/serial_chunk_adder_if.sv
// rtl/serial_chunk_adder_if.sv - start/operand/result bundle for serial_chunk_adder
interface serial_chunk_adder_if #(
  parameter int WIDTH = 16
) ();
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;

  modport master (
    output start, a, b, cin,
    input  busy, done, s, cout, ovf
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, s, cout, ovf
  );
endinterface

// File: rtl/serial_chunk_adder.sv
// rtl/serial_chunk_adder.sv - multi-cycle adder processing CHUNK bits per clock
module serial_chunk_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_chunk_adder_if.slave  bus
);

  localparam int NCH   = WIDTH / CHUNK;
  localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADD  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [CHUNK-1:0] a_ch;
  logic [CHUNK-1:0] b_ch;
  logic [CHUNK:0]   ch_sum;
  logic             msb_cin;

  // Pick the operand chunk addressed by the current index
  always_comb begin
    a_ch = '0;
    b_ch = '0;
    for (int k = 0; k < NCH; k++) begin
      if (idx_q == IDX_W'(k)) begin
        a_ch = a_q[k*CHUNK +: CHUNK];
        b_ch = b_q[k*CHUNK +: CHUNK];
      end
    end
  end

  assign ch_sum = {1'b0, a_ch} + {1'b0, b_ch} + {{CHUNK{1'b0}}, carry_q};

  // Carry into the chunk's top bit, recovered from that bit's sum; on the
  // last chunk this is the carry into bit WIDTH-1.
  assign msb_cin = a_ch[CHUNK-1] ^ b_ch[CHUNK-1] ^ ch_sum[CHUNK-1];

  // Next-state logic: accept in IDLE/DONE, one chunk per cycle in ADD
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_ADD: begin
        for (int k = 0; k < NCH; k++) begin
          if (idx_q == IDX_W'(k)) begin
            s_d[k*CHUNK +: CHUNK] = ch_sum[CHUNK-1:0];
          end
        end
        carry_d = ch_sum[CHUNK];
        if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
          idx_d   = '0;
          cout_d  = ch_sum[CHUNK];
          ovf_d   = msb_cin ^ ch_sum[CHUNK];
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      default: begin
        // IDLE and DONE both accept a new request; start in ADD never reaches here
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          carry_d = bus.cin;
          idx_d   = '0;
          state_d = S_ADD;
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.busy = (state_q == S_ADD);
  assign bus.done = (state_q == S_DONE);
  assign bus.s    = s_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_serial_chunk_adder.sv
// tb/tb_serial_chunk_adder.sv - randomized self-checking bench for serial_chunk_adder
module tb_serial_chunk_adder;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  serial_chunk_adder_if #(.WIDTH(16)) if16 ();
  serial_chunk_adder_if #(.WIDTH(8))  if8s ();
  serial_chunk_adder_if #(.WIDTH(8))  if8w ();

  serial_chunk_adder #(.WIDTH(16), .CHUNK(4)) u16  (.clk(clk), .rst_n(rst_n), .bus(if16));
  serial_chunk_adder #(.WIDTH(8),  .CHUNK(1)) u8s  (.clk(clk), .rst_n(rst_n), .bus(if8s));
  serial_chunk_adder #(.WIDTH(8),  .CHUNK(8)) u8w  (.clk(clk), .rst_n(rst_n), .bus(if8w));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int wid(input int w);
    return (w == 0) ? 16 : 8;
  endfunction

  function automatic int nch(input int w);
    return (w == 0) ? 4 : ((w == 1) ? 8 : 1);
  endfunction

  task automatic drive(input int w, input logic st, input logic [15:0] av,
                       input logic [15:0] bv, input logic ci);
    case (w)
      0: begin if16.start = st; if16.a = av;      if16.b = bv;      if16.cin = ci; end
      1: begin if8s.start = st; if8s.a = av[7:0]; if8s.b = bv[7:0]; if8s.cin = ci; end
      default: begin if8w.start = st; if8w.a = av[7:0]; if8w.b = bv[7:0]; if8w.cin = ci; end
    endcase
  endtask

  task automatic sample(input int w, output logic bz, output logic dn,
                        output logic [15:0] sv, output logic co, output logic ov);
    case (w)
      0: begin bz = if16.busy; dn = if16.done; sv = if16.s; co = if16.cout; ov = if16.ovf; end
      1: begin bz = if8s.busy; dn = if8s.done; sv = {8'h00, if8s.s}; co = if8s.cout; ov = if8s.ovf; end
      default: begin bz = if8w.busy; dn = if8w.done; sv = {8'h00, if8w.s}; co = if8w.cout; ov = if8w.ovf; end
    endcase
  endtask

  // Reference: plain integer arithmetic on unsigned and signed readings of the operands
  task automatic model(input int w, input logic [15:0] av, input logic [15:0] bv, input logic ci,
                       output logic [15:0] es, output logic ec, output logic eo);
    longint m, ua, ub, tot, lim, sa, sb, ss;
    m   = (longint'(1) << wid(w)) - 1;
    ua  = longint'(av) & m;
    ub  = longint'(bv) & m;
    tot = ua + ub + longint'(ci);
    es  = 16'(tot & m);
    ec  = ((tot >> wid(w)) & 1) != 0;
    lim = longint'(1) << (wid(w) - 1);
    sa  = (ua >= lim) ? ua - 2 * lim : ua;
    sb  = (ub >= lim) ? ub - 2 * lim : ub;
    ss  = sa + sb + longint'(ci);
    eo  = (ss >= lim) || (ss < -lim);
  endtask

  // Called at a negedge; returns at the negedge after the done cycle.
  // poke: busy-cycle number in which an extra start (0xFFFF+0xFFFF) is pulsed.
  task automatic run_op(input int w, input logic [15:0] av, input logic [15:0] bv,
                        input logic ci, input int poke, input string tag);
    logic [15:0] es, sv;
    logic        ec, eo, bz, dn, co, ov;
    int          busy_cnt;
    bit          got;
    model(w, av, bv, ci, es, ec, eo);
    drive(w, 1'b1, av, bv, ci);
    @(negedge clk);
    busy_cnt = 0;
    got = 0;
    for (int c = 0; c < 64 && !got; c++) begin
      sample(w, bz, dn, sv, co, ov);
      if (dn) begin
        got = 1;
      end else begin
        if (bz) busy_cnt++;
        if (bz && busy_cnt == poke) drive(w, 1'b1, 16'hFFFF, 16'hFFFF, 1'b1);
        else drive(w, 1'b0, 16'($urandom), 16'($urandom), 1'($urandom));
        @(negedge clk);
      end
    end
    drive(w, 1'b0, 16'($urandom), 16'($urandom), 1'($urandom));
    check({tag, "_done"}, 32'(got), 32'd1);
    check({tag, "_busy_cycles"}, busy_cnt, nch(w));
    check({tag, "_s"}, sv, es);
    check({tag, "_cout"}, co, ec);
    check({tag, "_ovf"}, ov, eo);
    @(negedge clk);
    sample(w, bz, dn, sv, co, ov);
    check({tag, "_pulse_len"}, dn, 1'b0);
    check({tag, "_s_held"}, sv, es);
  endtask

  // start held high; fresh operands presented in every DONE cycle
  task automatic back_to_back();
    logic [15:0] qa[$], qb[$];
    logic        qc[$];
    logic [15:0] na, nb, es, sv;
    logic        nc, ec, eo, bz, dn, co, ov;
    int          cyc, last, got;
    cyc = 0; last = 0; got = 0;
    na = 16'($urandom); nb = 16'($urandom); nc = 1'($urandom);
    qa.push_back(na); qb.push_back(nb); qc.push_back(nc);
    drive(0, 1'b1, na, nb, nc);
    for (int c = 0; c < 100 && got < 5; c++) begin
      @(negedge clk);
      cyc++;
      sample(0, bz, dn, sv, co, ov);
      if (dn) begin
        model(0, qa.pop_front(), qb.pop_front(), qc.pop_front(), es, ec, eo);
        check("b2b_s", sv, es);
        check("b2b_cout", co, ec);
        if (got > 0) check("b2b_gap", cyc - last, 5);
        last = cyc;
        got++;
        if (got < 5) begin
          na = 16'($urandom); nb = 16'($urandom); nc = 1'($urandom);
          qa.push_back(na); qb.push_back(nb); qc.push_back(nc);
          drive(0, 1'b1, na, nb, nc);
        end else begin
          drive(0, 1'b0, 16'h0, 16'h0, 1'b0);
        end
      end else begin
        drive(0, 1'b1, 16'($urandom), 16'($urandom), 1'($urandom));
      end
    end
    check("b2b_results", got, 5);
    @(negedge clk);
  endtask

  logic [15:0] r_s;
  logic        r_b, r_d, r_c, r_o;
  bit          seen;

  initial begin
    rst_n = 1'b0;
    for (int w = 0; w < 3; w++) drive(w, 1'b0, 16'h0, 16'h0, 1'b0);
    #1;
    for (int w = 0; w < 3; w++) begin
      sample(w, r_b, r_d, r_s, r_c, r_o);
      check($sformatf("rst%0d_busy", w), r_b, 1'b0);
      check($sformatf("rst%0d_done", w), r_d, 1'b0);
      check($sformatf("rst%0d_s", w), r_s, 16'h0);
      check($sformatf("rst%0d_cout", w), r_c, 1'b0);
      check($sformatf("rst%0d_ovf", w), r_o, 1'b0);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    // start presented for the very first edge after release
    run_op(0, 16'hFFFF, 16'h0001, 1'b0, -1, "wrap");
    run_op(0, 16'h7FFF, 16'h0001, 1'b0, -1, "sovf");
    run_op(0, 16'h1234, 16'h4321, 1'b1, -1, "cin1");
    run_op(0, 16'h1111, 16'h2222, 1'b0, 2, "ign_start");

    // reset in the third busy cycle
    drive(0, 1'b1, 16'h00FF, 16'h0001, 1'b0);
    @(negedge clk);
    drive(0, 1'b0, 16'($urandom), 16'($urandom), 1'b0);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    sample(0, r_b, r_d, r_s, r_c, r_o);
    check("midrst_busy", r_b, 1'b0);
    check("midrst_done", r_d, 1'b0);
    check("midrst_s", r_s, 16'h0);
    check("midrst_cout", r_c, 1'b0);
    check("midrst_ovf", r_o, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      sample(0, r_b, r_d, r_s, r_c, r_o);
      if (r_d || r_b) seen = 1;
    end
    check("midrst_no_done", 32'(seen), 32'd0);
    run_op(0, 16'h0001, 16'h0001, 1'b0, -1, "after_rst");

    back_to_back();

    run_op(1, 16'h00AA, 16'h0055, 1'b1, -1, "bitser");
    run_op(2, 16'h0080, 16'h0080, 1'b0, -1, "onechunk");

    repeat (12) run_op(0, 16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 5)), "rnd16");
    repeat (6) run_op(1, 16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 9)), "rnd8s");
    repeat (6) run_op(2, 16'($urandom), 16'($urandom), 1'($urandom), -1, "rnd8w");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/serial_chunk_adder.md
SERIAL_CHUNK_ADDER -- requirements
Module: serial_chunk_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning operand and sum width in bits.
REQ-002 SHALL have parameter CHUNK, default 4, meaning bits added per clock cycle; WIDTH SHALL be an integer multiple of CHUNK; NCH = WIDTH/CHUNK.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port start  input  1  request to begin an addition.
REQ-006 SHALL have port a  input  WIDTH  operand A, unsigned or two's complement.
REQ-007 SHALL have port b  input  WIDTH  operand B.
REQ-008 SHALL have port cin  input  1  carry into bit 0.
REQ-009 SHALL have port busy  output  1  high while chunks are being added.
REQ-010 SHALL have port done  output  1  one-cycle result-valid pulse.
REQ-011 SHALL have port s  output  WIDTH  sum, registered.
REQ-012 SHALL have port cout  output  1  carry out of bit WIDTH-1, registered.
REQ-013 SHALL have port ovf  output  1  signed overflow, registered; equals carry into MSB XOR cout.

Function
REQ-014 SHALL implement an FSM with states IDLE, ADD and DONE; busy = (state==ADD) and done = (state==DONE), both decoded from registered state.
REQ-015 In IDLE or DONE, start=1 at a rising edge (E0) SHALL latch a, b and cin into internal registers, clear chunk index to 0, load the carry register with cin, and go to ADD.
REQ-016 In ADD, each edge SHALL add chunk idx (bits idx*CHUNK .. idx*CHUNK+CHUNK-1) of the latched operands plus the carry register, write the CHUNK sum bits into s at the same position, update the carry register, and increment idx.
REQ-017 At the edge that processes chunk NCH-1, the FSM SHALL go to DONE and SHALL load cout with the final carry and ovf with (carry into bit WIDTH-1) XOR (final carry).
REQ-018 busy SHALL be high for exactly NCH cycles; done SHALL be high for exactly one cycle, starting NCH edges after E0 (edges E1..E_NCH process chunks; done is visible after E_NCH).
REQ-019 From DONE without start, the FSM SHALL go to IDLE; with start, it SHALL accept the new operands per REQ-015 (back-to-back throughput of one result per NCH+1 cycles).
REQ-020 start while in ADD SHALL be ignored; latched operands and progress SHALL be unaffected.
REQ-021 Changes on a, b or cin after E0 SHALL NOT affect the result in progress.
REQ-022 s, cout and ovf SHALL be valid from the done cycle and SHALL be held unchanged until the next accepted start; during ADD, only s bits of already-processed chunks are defined.
REQ-023 Sum arithmetic SHALL be modulo 2^WIDTH; {cout,s} SHALL equal a + b + cin exactly.
REQ-024 CHUNK == WIDTH SHALL be legal (NCH=1: busy one cycle, then done); CHUNK == 1 SHALL be legal (pure bit-serial).

Reset
REQ-025 rst_n low SHALL immediately, without a clock, force state to IDLE, idx to 0, the carry register to 0, and s, cout and ovf to 0; busy and done SHALL therefore be 0.
REQ-026 Reset asserted mid-ADD SHALL abandon the operation; no done pulse SHALL follow, and the first start after rst_n rises SHALL behave as from power-up.
REQ-027 start sampled on the first edge after reset release SHALL be accepted normally.

Verification
REQ-028 WIDTH=16, CHUNK=4: a=0xFFFF, b=0x0001, cin=0, start for one cycle -> busy high for 4 cycles, then done for 1 cycle with s=0x0000, cout=1, ovf=0.
REQ-029 a=0x7FFF, b=0x0001, cin=0 -> s=0x8000, cout=0, ovf=1; with a=0x1234, b=0x4321, cin=1 -> s=0x5556, cout=0, ovf=0.
REQ-030 Start 0x1111+0x2222; pulse start with 0xFFFF+0xFFFF during the 2nd busy cycle and change a/b after E0 -> the second start is ignored, and done reports s=0x3333, cout=0.
REQ-031 Start 0x00FF+0x0001, assert rst_n low in the 3rd busy cycle -> busy, done, s, cout and ovf are immediately 0; no done pulse follows; the next 0x0001+0x0001 gives s=0x0002 after 4 busy cycles.
REQ-032 Hold start high continuously with new operands presented in each DONE cycle -> results arrive every 5 cycles, and each s matches the operands present at its accepting edge.
REQ-033 WIDTH=8, CHUNK=1: a=0xAA, b=0x55, cin=1 -> busy for 8 cycles, then s=0x00, cout=1, ovf=0; WIDTH=8, CHUNK=8: 0x80+0x80 -> busy for 1 cycle, then s=0x00, cout=1, ovf=1.
